// File: rtl/noc_input_fifo.sv
// ----------------------------------------------------------------------------
// noc_input_fifo
// Per-port input buffer of the NoC router, sitting directly in front of the
// LBDR routing stage. Flits are stored in a small circular buffer and the
// head flit is presented first-word-fall-through. A framing checker on the
// write side admits only HEADER, PAYLOAD*, TAIL sequences and drops anything
// else with a one-cycle frame_err pulse.
//
// Ports:
//   clk        router clock, rising-edge
//   rst        asynchronous active-low reset
//   wr_en      upstream write request
//   din        incoming flit
//   rd_en      pop of the head flit
//   dout       head flit (combinational from memory at rd_ptr)
//   flit_id    dout[DATA_WIDTH-1:DATA_WIDTH-3]
//   dst_addr   dout[3:0], meaningful when flit_id is HEADER
//   empty      occupancy is zero (registered)
//   full       occupancy is DEPTH (registered)
//   count      current occupancy
//   frame_err  one-cycle pulse per flit dropped for a framing violation
//   credit_out one-cycle pulse after each accepted read
//              (only when NOC_FIFO_CREDIT_EN is defined)
//
// Optional feature macro: NOC_FIFO_CREDIT_EN
// ----------------------------------------------------------------------------
module noc_input_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [2:0]            flit_id,
    output logic [3:0]            dst_addr,
    output logic                  empty,
    output logic                  full,
    output logic [PTR_W:0]        count,
    output logic                  frame_err
`ifdef NOC_FIFO_CREDIT_EN
    ,
    output logic                  credit_out
`endif
);

    // Flit type codes shared with the rest of the router.
    localparam logic [2:0] FLIT_HEADER  = 3'b001;
    localparam logic [2:0] FLIT_PAYLOAD = 3'b010;
    localparam logic [2:0] FLIT_TAIL    = 3'b100;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        IN_PKT
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    state_t                state;

    logic                  rd_ok;
    logic                  wr_elig;
    logic                  accept;
    logic                  wr_ok;
    logic                  drop;
    logic [2:0]            in_id;
    logic [PTR_W:0]        count_next;
    state_t                state_next;

    assign dout     = mem[rd_ptr];
    assign flit_id  = dout[DATA_WIDTH-1:DATA_WIDTH-3];
    assign dst_addr = dout[3:0];
    assign in_id    = din[DATA_WIDTH-1:DATA_WIDTH-3];

    // A read frees a slot in the same cycle, so a full FIFO still takes a
    // write when it is being popped.
    assign rd_ok   = rd_en & ~empty;
    assign wr_elig = wr_en & (~full | rd_ok);

    always_comb begin
        accept     = 1'b0;
        state_next = state;
        unique case (state)
            IDLE: begin
                if (in_id == FLIT_HEADER) begin
                    accept     = 1'b1;
                    state_next = IN_PKT;
                end
            end
            IN_PKT: begin
                if (in_id == FLIT_PAYLOAD) begin
                    accept = 1'b1;
                end else if (in_id == FLIT_TAIL) begin
                    accept     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: accept = 1'b0;
        endcase
    end

    assign wr_ok = wr_elig & accept;
    assign drop  = wr_elig & ~accept;

    always_comb begin
        count_next = count;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            frame_err <= 1'b0;
            state     <= IDLE;
        end else begin
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            count     <= count_next;
            empty     <= (count_next == '0);
            full      <= (count_next == FULL_CNT);
            frame_err <= drop;
            if (wr_elig) state <= state_next;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= din;
    end

`ifdef NOC_FIFO_CREDIT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) credit_out <= 1'b0;
        else      credit_out <= rd_ok;
    end
`endif

endmodule

// File: tb/tb_noc_input_fifo.sv
module tb_noc_input_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam logic [2:0] H = 3'b001;
    localparam logic [2:0] P = 3'b010;
    localparam logic [2:0] T = 3'b100;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] dout;
    logic [2:0]    flit_id;
    logic [3:0]    dst_addr;
    logic          empty;
    logic          full;
    logic [2:0]    count;
    logic          frame_err;
`ifdef NOC_FIFO_CREDIT_EN
    logic          credit_out;
`endif

    noc_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .din       (din),
        .rd_en     (rd_en),
        .dout      (dout),
        .flit_id   (flit_id),
        .dst_addr  (dst_addr),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .frame_err (frame_err)
`ifdef NOC_FIFO_CREDIT_EN
        ,
        .credit_out(credit_out)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of stored flits plus an "inside a packet" flag.
    logic [DW-1:0] q[$];
    bit            in_pkt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [2:0] id, input logic [3:0] dst);
        logic [31:0] r;
        r = $urandom();
        return {id, r[24:0], dst};
    endfunction

    // One clock cycle: drive at negedge, let the edge happen, then compare
    // every visible output against the model.
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
        bit rd_ok, elig, ok, exp_err;
        logic [2:0] id;
        @(negedge clk);
        wr_en = w; din = d; rd_en = r;
        id    = d[DW-1:DW-3];
        rd_ok = r && (q.size() > 0);
        elig  = w && ((q.size() < DEPTH) || rd_ok);
        ok    = in_pkt ? (id == P || id == T) : (id == H);
        exp_err = elig && !ok;
        @(posedge clk);
        #1;
        if (rd_ok) void'(q.pop_front());
        if (elig && ok) begin
            q.push_back(d);
            if (id == H) in_pkt = 1;
            if (id == T) in_pkt = 0;
        end
        chk("count", 64'(count), 64'(q.size()));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("full", 64'(full), 64'(q.size() == DEPTH));
        chk("frame_err", 64'(frame_err), 64'(exp_err));
`ifdef NOC_FIFO_CREDIT_EN
        chk("credit_out", 64'(credit_out), 64'(rd_ok));
`endif
        if (q.size() > 0) begin
            chk("dout", 64'(dout), 64'(q[0]));
            chk("flit_id", 64'(flit_id), 64'(q[0][DW-1:DW-3]));
            chk("dst_addr", 64'(dst_addr), 64'(q[0][3:0]));
        end
        wr_en = 0; rd_en = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) step(0, '0, 1);
    endtask

    logic [DW-1:0] hdr;
    logic [DW-1:0] f;
    int            wr_count;

    initial begin
        // Reset held for two cycles.
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        @(negedge clk);
        rst = 1;
        idle(3);

        // Single packet, filling the FIFO exactly.
        hdr = mk(H, 4'b1000);
        step(1, hdr, 0);
        step(1, mk(P, 4'h3), 0);
        step(1, mk(P, 4'h5), 0);
        step(1, mk(T, 4'h7), 0);
        chk("pkt_full", 64'(full), 64'd1);
        chk("pkt_count", 64'(count), 64'd4);
        chk("pkt_head_id", 64'(flit_id), 64'(H));
        chk("pkt_head_dst", 64'(dst_addr), 64'h8);

        // Full boundary: lone write is lost, write with read is kept.
        step(1, mk(H, 4'h1), 0);
        chk("full_drop_count", 64'(count), 64'd4);
        f = mk(H, 4'h9);
        step(1, f, 1);
        chk("full_rw_count", 64'(count), 64'd4);
        step(0, '0, 1);
        step(0, '0, 1);
        step(0, '0, 1);
        chk("full_rw_fourth", 64'(dout), 64'(f));
        step(0, '0, 1);
        chk("full_rw_empty", 64'(empty), 64'd1);
        step(1, mk(T, 4'h0), 0);    // closes the packet opened by f
        drain();

        // Framing errors.
        step(1, mk(P, 4'h2), 0);
        chk("idle_payload_err", 64'(frame_err), 64'd1);
        step(0, '0, 0);
        chk("err_one_cycle", 64'(frame_err), 64'd0);
        step(1, mk(H, 4'h4), 0);
        step(1, mk(H, 4'h6), 0);
        chk("dup_header_err", 64'(frame_err), 64'd1);
        step(1, mk(T, 4'h0), 0);
        chk("tail_after_dup", 64'(count), 64'd2);
        step(1, mk(P, 4'h0), 0);
        chk("back_to_idle_err", 64'(frame_err), 64'd1);
        drain();

        // Wrap-around: 10 header+tail packets with interleaved reads.
        wr_count = 0;
        while (wr_count < 20) begin
            bit r;
            r = ($urandom_range(0, 1) == 1) || (q.size() == DEPTH);
            step(1, mk((wr_count % 2 == 0) ? H : T, 4'($urandom())), r);
            wr_count++;
        end
        drain();
        chk("wrap_empty", 64'(empty), 64'd1);

`ifdef NOC_FIFO_CREDIT_EN
        // Three consecutive reads give three consecutive credit cycles.
        step(1, mk(H, 4'h1), 0);
        step(1, mk(P, 4'h2), 0);
        step(1, mk(T, 4'h3), 0);
        step(0, '0, 1);
        chk("credit_1", 64'(credit_out), 64'd1);
        step(0, '0, 1);
        chk("credit_2", 64'(credit_out), 64'd1);
        step(0, '0, 1);
        chk("credit_3", 64'(credit_out), 64'd1);
        step(0, '0, 0);
        chk("credit_end", 64'(credit_out), 64'd0);
`endif

        // Random traffic with legal upstream behaviour (never writes into a
        // full FIFO without a read in the same cycle).
        for (int i = 0; i < 400; i++) begin
            bit w, r;
            logic [2:0] id;
            int sel;
            sel = int'($urandom_range(0, 9));
            id  = (sel < 3) ? H : (sel < 6) ? P : (sel < 9) ? T : 3'($urandom_range(0, 7));
            r   = ($urandom_range(0, 2) != 0);
            w   = ($urandom_range(0, 3) != 0);
            if (q.size() == DEPTH && !r) w = 0;
            step(w, mk(id, 4'($urandom())), r);
        end
        drain();

        // Mid-packet asynchronous reset.
        if (in_pkt) step(1, mk(T, 4'h0), 0);
        drain();
        step(1, mk(H, 4'hA), 0);
        step(1, mk(P, 4'hB), 0);
        @(negedge clk);
        #2;
        rst = 0;
        #1;
        chk("async_rst_empty", 64'(empty), 64'd1);
        chk("async_rst_count", 64'(count), 64'd0);
        q.delete();
        in_pkt = 0;
        #1;
        rst = 1;
        step(1, mk(P, 4'hC), 0);
        chk("post_rst_payload_err", 64'(frame_err), 64'd1);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
